// File: rtl/hazard_stall_controller_if.sv
// Decoder/pipeline handshake bundle for the hazard and stall controller.
// master = pipeline datapath side, slave = the controller.
interface hazard_stall_controller_if #(
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_rf_we;
    logic              id_load;
    logic [REG_AW-1:0] id_dest;
    logic              id_flush_req;
    logic              mem_op;
    logic              mem_ready;

    logic              pc_le;
    logic              ifid_le;
    logic              ifid_flush;
    logic              idex_le;
    logic              exmem_le;
    logic              cmux;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              mem_timeout;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rf_we,
               id_load, id_dest, id_flush_req, mem_op, mem_ready,
        input  pc_le, ifid_le, ifid_flush, idex_le, exmem_le, cmux,
               fwd_a_sel, fwd_b_sel, mem_timeout
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rf_we,
               id_load, id_dest, id_flush_req, mem_op, mem_ready,
        output pc_le, ifid_le, ifid_flush, idex_le, exmem_le, cmux,
               fwd_a_sel, fwd_b_sel, mem_timeout
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// 5-stage pipeline sequencer: scoreboard shadow, load-use bubbles, ID forwarding, IF/ID flush.
// Outputs are combinational from state/scoreboard; mem_ready low freezes every stage (bounded by MEM_TIMEOUT).
module hazard_stall_controller #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    hazard_stall_controller_if.slave  bus
);

    typedef struct packed {
        logic              v;
        logic              we;
        logic              load;
        logic [REG_AW-1:0] dest;
    } sb_entry_t;

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    sb_entry_t  ex_s;
    sb_entry_t  mem_s;
    sb_entry_t  wb_s;
    logic       freeze;
    logic       timeout_hit;
    logic       lu_stall;
    logic       rs_hit;
    logic       rt_hit;

    // EX is skipped for loads: their data is not ready until MEM, and the
    // load-use bubble guarantees the consumer sees the load one stage later.
    function automatic logic [1:0] fwd_sel(
        input logic              use_src,
        input logic [REG_AW-1:0] addr,
        input sb_entry_t         ex_e,
        input sb_entry_t         mem_e,
        input sb_entry_t         wb_e
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && (addr != '0)) begin
            if (ex_e.v && ex_e.we && !ex_e.load && (ex_e.dest == addr))
                sel = 2'b01;
            else if (mem_e.v && mem_e.we && (mem_e.dest == addr))
                sel = 2'b10;
            else if (wb_e.v && wb_e.we && (wb_e.dest == addr))
                sel = 2'b11;
        end
        return sel;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        freeze       = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            RUN: begin
                freeze       = mem_s.v && bus.mem_op && !bus.mem_ready;
                wait_cnt_nxt = '0;
                if (freeze)
                    state_nxt = WAIT_MEM;
            end
            WAIT_MEM: begin
                freeze      = !bus.mem_ready && (wait_cnt < TIMEOUT_CNT);
                timeout_hit = !bus.mem_ready && (wait_cnt >= TIMEOUT_CNT);
                if (bus.mem_ready || (wait_cnt >= TIMEOUT_CNT)) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        rs_hit   = bus.id_use_rs && (bus.id_rs == ex_s.dest);
        rt_hit   = bus.id_use_rt && (bus.id_rt == ex_s.dest);
        lu_stall = !freeze && bus.id_valid && ex_s.v && ex_s.load &&
                   (ex_s.dest != '0) && (rs_hit || rt_hit);
    end

    always_comb begin
        bus.pc_le    = 1'b1;
        bus.ifid_le  = 1'b1;
        bus.idex_le  = 1'b1;
        bus.exmem_le = 1'b1;
        bus.cmux     = 1'b1;
        if (freeze) begin
            bus.pc_le    = 1'b0;
            bus.ifid_le  = 1'b0;
            bus.idex_le  = 1'b0;
            bus.exmem_le = 1'b0;
        end else if (lu_stall) begin
            bus.pc_le   = 1'b0;
            bus.ifid_le = 1'b0;
            bus.cmux    = 1'b0;
        end
        // A stalled branch keeps its request asserted and flushes once released.
        bus.ifid_flush  = bus.id_flush_req && !freeze && !lu_stall && !reset;
        bus.mem_timeout = timeout_hit;
        bus.fwd_a_sel   = fwd_sel(bus.id_use_rs, bus.id_rs, ex_s, mem_s, wb_s);
        bus.fwd_b_sel   = fwd_sel(bus.id_use_rt, bus.id_rt, ex_s, mem_s, wb_s);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_s  <= '0;
            mem_s <= '0;
            wb_s  <= '0;
        end else if (!freeze) begin
            mem_s <= ex_s;
            wb_s  <= mem_s;
            if (lu_stall)
                ex_s <= '0;
            else
                ex_s <= '{v: bus.id_valid, we: bus.id_rf_we,
                          load: bus.id_load, dest: bus.id_dest};
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench for hazard_stall_controller with hand-computed expectations.
module tb_hazard_stall_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_stall_controller_if #(.REG_AW(5)) bus ();

    hazard_stall_controller #(.REG_AW(5), .MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {pc_le, ifid_le, idex_le, exmem_le, cmux}
    localparam logic [7:0] RUNV  = 8'h1F;
    localparam logic [7:0] STALL = 8'h06;
    localparam logic [7:0] FRZ   = 8'h01;

    logic [7:0] le8, fa8, fb8, fl8, to8;
    assign le8 = {3'b000, bus.pc_le, bus.ifid_le, bus.idex_le, bus.exmem_le, bus.cmux};
    assign fa8 = {6'b0, bus.fwd_a_sel};
    assign fb8 = {6'b0, bus.fwd_b_sel};
    assign fl8 = {7'b0, bus.ifid_flush};
    assign to8 = {7'b0, bus.mem_timeout};

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic we,
                      input logic ld, input logic [4:0] dest);
        bus.id_valid  = v;
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.id_use_rs = urs;
        bus.id_use_rt = urt;
        bus.id_rf_we  = we;
        bus.id_load   = ld;
        bus.id_dest   = dest;
    endtask

    task automatic idle();
        id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        reset            = 1'b0;
        idle();
        bus.id_flush_req = 1'b0;
        bus.mem_op       = 1'b0;
        bus.mem_ready    = 1'b1;
        #1 reset = 1'b1;
        settle();
        chk("rst_le", le8, RUNV);
        chk("rst_flush", fl8, 8'd0);
        chk("rst_fwda", fa8, 8'd0);
        chk("rst_fwdb", fb8, 8'd0);
        chk("rst_timeout", to8, 8'd0);
        tick();
        tick();
        reset = 1'b0;

        // lw $5 ; addu $6,$5,$7 -> one bubble, then forward from MEM
        id(1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd5);
        settle();
        chk("t1_lw_le", le8, RUNV);
        tick();
        id(1, 5'd5, 5'd7, 1, 1, 1, 0, 5'd6);
        settle();
        chk("t1_stall_le", le8, STALL);
        chk("t1_stall_fwda", fa8, 8'd0);
        tick();
        settle();
        chk("t1_resume_le", le8, RUNV);
        chk("t1_fwda_mem", fa8, 8'd2);
        chk("t1_fwdb_none", fb8, 8'd0);
        tick();
        idle();
        repeat (3) tick();

        // addu $3 ; subu $4,$3,$3 -> EX forwarding both sides; $0 never forwarded
        id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3);
        settle();
        chk("t2_add_le", le8, RUNV);
        tick();
        id(1, 5'd3, 5'd3, 1, 1, 1, 0, 5'd4);
        settle();
        chk("t2_sub_le", le8, RUNV);
        chk("t2_fwda_ex", fa8, 8'd1);
        chk("t2_fwdb_ex", fb8, 8'd1);
        tick();
        id(1, 5'd9, 5'd9, 1, 1, 1, 0, 5'd0);
        settle();
        chk("t2_nomatch_a", fa8, 8'd0);
        tick();
        id(1, 5'd0, 5'd3, 1, 1, 1, 0, 5'd10);
        settle();
        chk("t2_zero_a", fa8, 8'd0);
        chk("t2_wb_b", fb8, 8'd3);
        tick();
        id(1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd0);
        tick();
        id(1, 5'd0, 5'd0, 1, 1, 1, 0, 5'd11);
        settle();
        chk("t2_lw0_nostall", le8, RUNV);
        tick();
        idle();
        repeat (3) tick();

        // store stuck in MEM for 3 cycles -> frozen, scoreboard preserved
        id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd8);
        tick();
        id(1, 5'd8, 5'd2, 1, 1, 0, 0, 5'd0);
        settle();
        chk("t3_sw_fwda", fa8, 8'd1);
        tick();
        idle();
        tick();
        id(1, 5'd8, 5'd0, 1, 0, 0, 0, 5'd0);
        bus.mem_op    = 1'b1;
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("t3_frz%0d", k), le8, FRZ);
            chk($sformatf("t3_fwda_wb%0d", k), fa8, 8'd3);
            chk($sformatf("t3_nopulse%0d", k), to8, 8'd0);
            tick();
        end
        bus.mem_ready = 1'b1;
        settle();
        chk("t3_release_le", le8, RUNV);
        chk("t3_release_fwda", fa8, 8'd3);
        chk("t3_release_pulse", to8, 8'd0);
        tick();
        bus.mem_op = 1'b0;
        settle();
        chk("t3_retired_fwda", fa8, 8'd0);
        idle();
        repeat (3) tick();

        // memory never ready -> 16 frozen cycles then forced release with a pulse
        id(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
        tick();
        idle();
        tick();
        bus.mem_op    = 1'b1;
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            settle();
            chk($sformatf("t4_frz%0d", k), le8, FRZ);
            chk($sformatf("t4_nopulse%0d", k), to8, 8'd0);
            tick();
        end
        settle();
        chk("t4_forced_le", le8, RUNV);
        chk("t4_pulse", to8, 8'd1);
        tick();
        settle();
        chk("t4_after_le", le8, RUNV);
        chk("t4_pulse_gone", to8, 8'd0);
        bus.mem_op    = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        repeat (3) tick();

        // load-use with a taken branch in ID -> flush held off for the stall cycle
        id(1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd5);
        tick();
        id(1, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0);
        bus.id_flush_req = 1'b1;
        settle();
        chk("t5_stall_le", le8, STALL);
        chk("t5_stall_flush", fl8, 8'd0);
        tick();
        settle();
        chk("t5_flush", fl8, 8'd1);
        chk("t5_fwda", fa8, 8'd2);
        tick();
        bus.id_flush_req = 1'b0;
        idle();
        repeat (3) tick();

        // freeze beats load-use; reset inside WAIT_MEM restores reset outputs at once
        id(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
        tick();
        id(1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd5);
        tick();
        id(1, 5'd5, 5'd0, 1, 0, 1, 0, 5'd6);
        bus.mem_op    = 1'b1;
        bus.mem_ready = 1'b0;
        settle();
        chk("t6_freeze_wins", le8, FRZ);
        tick();
        settle();
        chk("t6_waitmem_le", le8, FRZ);
        reset = 1'b1;
        #1;
        chk("t6_rst_le", le8, RUNV);
        chk("t6_rst_fwda", fa8, 8'd0);
        chk("t6_rst_pulse", to8, 8'd0);
        chk("t6_rst_flush", fl8, 8'd0);
        tick();
        reset         = 1'b0;
        bus.mem_op    = 1'b0;
        bus.mem_ready = 1'b1;
        settle();
        chk("t6_post_le", le8, RUNV);
        chk("t6_post_fwda", fa8, 8'd0);
        chk("t6_post_pulse", to8, 8'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
